// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
// Bundles the two requester ports and the data-memory bus of mem_access_ctrl.
//
// Handshake: a requester raises pN_req with all fields stable and holds them
// until pN_ack pulses for one cycle (pN_err valid alongside). In the cycle after
// ack the requester drops req or presents a new request.
//
// Signals (N = 0, 1):
//   pN_req, pN_we, pN_addr, pN_size, pN_uns, pN_wdata : requester -> controller
//   pN_rdata, pN_ack, pN_err                           : controller -> requester
//   mem_endr, mem_we, mem_din                          : controller -> memory
//   mem_dout                                           : memory -> controller
// Modports:
//   slave  : controller view
//   master : requester/memory-side view (testbench)
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [1:0]        p0_size;
    logic              p0_uns;
    logic [63:0]       p0_wdata;
    logic [63:0]       p0_rdata;
    logic              p0_ack;
    logic              p0_err;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [1:0]        p1_size;
    logic              p1_uns;
    logic [63:0]       p1_wdata;
    logic [63:0]       p1_rdata;
    logic              p1_ack;
    logic              p1_err;

    logic [ADDR_W-4:0] mem_endr;
    logic              mem_we;
    logic [63:0]       mem_din;
    logic [63:0]       mem_dout;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_size, p0_uns, p0_wdata,
        output p0_rdata, p0_ack, p0_err,
        input  p1_req, p1_we, p1_addr, p1_size, p1_uns, p1_wdata,
        output p1_rdata, p1_ack, p1_err,
        output mem_endr, mem_we, mem_din,
        input  mem_dout
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_size, p0_uns, p0_wdata,
        input  p0_rdata, p0_ack, p0_err,
        output p1_req, p1_we, p1_addr, p1_size, p1_uns, p1_wdata,
        input  p1_rdata, p1_ack, p1_err,
        input  mem_endr, mem_we, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Load/store sequencer and two-port round-robin arbiter in front of a
// 64-bit x 32-entry data memory (combinational read, synchronous write).
// Byte/half/word/doubleword accesses; sub-doubleword stores use
// read-modify-write; loads are zero- or sign-extended.
//
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : mem_access_ctrl_if.slave (requester ports 0/1 + memory bus)
//   o_dbg_state : current FSM state (0 IDLE, 1 ACCESS, 2 WRITE, 3 RESP)
//
// Configuration macro: MEMCTRL_DEBUG_PORT_EN
//   defined   : port 1 fully functional, round-robin arbitration
//   undefined : p1_req ignored, port 1 outputs tied to 0, port 0 always granted
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_access_ctrl_if.slave     bus,
    output logic [1:0]           o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WRITE  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_we;
    logic              r_uns;
    logic [1:0]        r_size;
    logic [2:0]        r_off;
    logic [63:0]       r_wdata;
    logic [ADDR_W-4:0] r_mem_endr;
    logic              r_mem_we;
    logic [63:0]       r_mem_din;   // doubles as the RMW merge register
    logic              r_ack;
    logic              r_err;
    logic [63:0]       r_rdata0;
`ifdef MEMCTRL_DEBUG_PORT_EN
    logic              r_gnt;       // port owning the current transaction
    logic              r_last;      // last granted port, resets to 1
    logic [63:0]       r_rdata1;
    logic              w_gnt;
`endif

    logic              w_req_any;
    logic              w_we;
    logic              w_uns;
    logic [1:0]        w_size;
    logic [ADDR_W-1:0] w_addr;
    logic [63:0]       w_wdata;
    logic              w_misal;

    // Arbitration and request field selection in IDLE.
    always_comb begin
        w_we    = bus.p0_we;
        w_uns   = bus.p0_uns;
        w_size  = bus.p0_size;
        w_addr  = bus.p0_addr;
        w_wdata = bus.p0_wdata;
`ifdef MEMCTRL_DEBUG_PORT_EN
        w_req_any = bus.p0_req | bus.p1_req;
        // On a tie the port not granted last wins; a lone requester always wins.
        if (bus.p0_req && bus.p1_req) begin
            w_gnt = ~r_last;
        end else begin
            w_gnt = bus.p1_req;
        end
        if (w_gnt) begin
            w_we    = bus.p1_we;
            w_uns   = bus.p1_uns;
            w_size  = bus.p1_size;
            w_addr  = bus.p1_addr;
            w_wdata = bus.p1_wdata;
        end
`else
        w_req_any = bus.p0_req;
`endif
        case (w_size)
            2'b01:   w_misal = w_addr[0];
            2'b10:   w_misal = |w_addr[1:0];
            2'b11:   w_misal = |w_addr[2:0];
            default: w_misal = 1'b0;
        endcase
    end

    logic [5:0]  w_bitoff;
    logic [63:0] w_shift;
    logic [63:0] w_load;
    logic [63:0] w_lane_mask;
    logic [63:0] w_merge;

    // Lane extraction for loads and lane merge for RMW stores, both driven
    // from the captured request and the memory word currently addressed.
    always_comb begin
        w_bitoff = {r_off, 3'b000};
        w_shift  = bus.mem_dout >> w_bitoff;
        case (r_size)
            2'b00: begin
                w_lane_mask = 64'h0000_0000_0000_00FF;
                w_load = r_uns ? {56'd0, w_shift[7:0]} : {{56{w_shift[7]}}, w_shift[7:0]};
            end
            2'b01: begin
                w_lane_mask = 64'h0000_0000_0000_FFFF;
                w_load = r_uns ? {48'd0, w_shift[15:0]} : {{48{w_shift[15]}}, w_shift[15:0]};
            end
            2'b10: begin
                w_lane_mask = 64'h0000_0000_FFFF_FFFF;
                w_load = r_uns ? {32'd0, w_shift[31:0]} : {{32{w_shift[31]}}, w_shift[31:0]};
            end
            default: begin
                w_lane_mask = '1;
                w_load      = w_shift;
            end
        endcase
        w_merge = (bus.mem_dout & ~(w_lane_mask << w_bitoff)) |
                  ((r_wdata & w_lane_mask) << w_bitoff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_size     <= 2'b00;
            r_off      <= 3'd0;
            r_wdata    <= '0;
            r_mem_endr <= '0;
            r_mem_we   <= 1'b0;
            r_mem_din  <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rdata0   <= '0;
`ifdef MEMCTRL_DEBUG_PORT_EN
            r_gnt      <= 1'b0;
            r_last     <= 1'b1;
            r_rdata1   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_we       <= w_we;
                        r_uns      <= w_uns;
                        r_size     <= w_size;
                        r_off      <= w_addr[2:0];
                        r_wdata    <= w_wdata;
                        r_mem_endr <= w_addr[ADDR_W-1:3];
`ifdef MEMCTRL_DEBUG_PORT_EN
                        r_gnt      <= w_gnt;
                        r_last     <= w_gnt;
`endif
                        if (w_misal) begin
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            // A doubleword store writes straight out of ACCESS.
                            r_mem_we <= w_we && (w_size == 2'b11);
                            if (w_we) begin
                                r_mem_din <= w_wdata;
                            end
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!r_we) begin
`ifdef MEMCTRL_DEBUG_PORT_EN
                        if (r_gnt) r_rdata1 <= w_load;
                        else
`endif
                        r_rdata0 <= w_load;
                        r_ack    <= 1'b1;
                        r_state  <= S_RESP;
                    end else if (r_size == 2'b11) begin
                        r_mem_we <= 1'b0;
                        r_ack    <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_mem_din <= w_merge;
                        r_mem_we  <= 1'b1;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_mem_we <= 1'b0;
                    r_ack    <= 1'b1;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_endr = r_mem_endr;
    assign bus.mem_we   = r_mem_we;
    assign bus.mem_din  = r_mem_din;
    assign bus.p0_rdata = r_rdata0;
    assign o_dbg_state  = r_state;
`ifdef MEMCTRL_DEBUG_PORT_EN
    assign bus.p0_ack   = r_ack & ~r_gnt;
    assign bus.p0_err   = r_err & ~r_gnt;
    assign bus.p1_ack   = r_ack & r_gnt;
    assign bus.p1_err   = r_err & r_gnt;
    assign bus.p1_rdata = r_rdata1;
`else
    assign bus.p0_ack   = r_ack;
    assign bus.p0_err   = r_err;
    assign bus.p1_ack   = 1'b0;
    assign bus.p1_err   = 1'b0;
    assign bus.p1_rdata = '0;
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Bench for mem_access_ctrl: directed table, random transactions against a
// byte-array reference memory, reset during RMW, and port-1 behaviour
// (arbitration when MEMCTRL_DEBUG_PORT_EN is defined, ignored otherwise).
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(8)) bus();

    mem_access_ctrl #(.ADDR_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // Data memory: combinational read, write on rising edge.
    logic [63:0] mem [32];
    assign bus.mem_dout = mem[bus.mem_endr];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_endr] <= bus.mem_din;
    end

    // Scoreboard counters and reference model.
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  ref_mem [256];
    logic [63:0] exp_rdata [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_load(input int a, input int sz, input bit uns);
        int n;
        logic [63:0] v;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
        if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    task automatic ref_store(input int a, input int sz, input logic [63:0] d);
        for (int i = 0; i < (1 << sz); i++) ref_mem[a + i] = d[8*i +: 8];
    endtask

    function automatic logic [63:0] ref_word(input int w);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[8*w + i];
        return v;
    endfunction

    // Drive one request from a fresh IDLE cycle and wait (bounded) for its ack.
    task automatic do_txn(input bit port, input bit we, input logic [7:0] addr,
                          input logic [1:0] size, input bit uns, input logic [63:0] wdata,
                          output int lat, output bit err, output logic [63:0] rdata,
                          output int we_cyc, output bit other_ack);
        @(posedge clk); #1;
        if (port == 1'b0) begin
            bus.p0_we = we; bus.p0_addr = addr; bus.p0_size = size;
            bus.p0_uns = uns; bus.p0_wdata = wdata; bus.p0_req = 1'b1;
        end else begin
            bus.p1_we = we; bus.p1_addr = addr; bus.p1_size = size;
            bus.p1_uns = uns; bus.p1_wdata = wdata; bus.p1_req = 1'b1;
        end
        lat = -1; err = 1'b0; rdata = '0; we_cyc = 0; other_ack = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (bus.mem_we) we_cyc++;
            if ((port == 1'b0) ? bus.p1_ack : bus.p0_ack) other_ack = 1'b1;
            if ((port == 1'b0) ? bus.p0_ack : bus.p1_ack) begin
                lat   = k;
                err   = (port == 1'b0) ? bus.p0_err : bus.p1_err;
                rdata = (port == 1'b0) ? bus.p0_rdata : bus.p1_rdata;
                break;
            end
        end
        if (port == 1'b0) bus.p0_req = 1'b0;
        else              bus.p1_req = 1'b0;
    endtask

    // Random/model-checked transaction: expectations from ref_mem and size rules.
    task automatic run_check(input bit port, input bit we, input logic [7:0] addr,
                             input logic [1:0] size, input bit uns, input logic [63:0] wdata);
        int n, exp_lat, exp_wc, lat, wc;
        bit mis, err, oth;
        logic [63:0] rd;
        n   = 1 << size;
        mis = (int'(addr) % n) != 0;
        if (mis)              exp_lat = 1;
        else if (!we)         exp_lat = 2;
        else if (size == 2'd3) exp_lat = 2;
        else                  exp_lat = 3;
        exp_wc = (mis || !we) ? 0 : 1;
        if (!mis && !we) exp_rdata[port] = ref_load(int'(addr), int'(size), uns);
        if (!mis && we)  ref_store(int'(addr), int'(size), wdata);
        do_txn(port, we, addr, size, uns, wdata, lat, err, rd, wc, oth);
        check("rnd_latency", 64'(lat), 64'(exp_lat));
        check("rnd_err", 64'(err), 64'(mis));
        check("rnd_rdata", rd, exp_rdata[port]);
        check("rnd_mem_we_cycles", 64'(wc), 64'(exp_wc));
        check("rnd_other_ack", 64'(oth), 64'd0);
        if (!mis && we) check("rnd_mem_word", mem[addr[7:3]], ref_word(int'(addr[7:3])));
    endtask

    typedef struct {
        bit          we;
        logic [7:0]  addr;
        logic [1:0]  size;
        bit          uns;
        logic [63:0] wdata;
        int          lat;
        bit          err;
        logic [63:0] rdata;
        int          widx;
        logic [63:0] wval;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, wc;
        bit          err, oth;
        logic [63:0] rd;
        logic [7:0]  a;
        int          sz;

        bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = 0; bus.p0_size = 0; bus.p0_uns = 0; bus.p0_wdata = 0;
        bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = 0; bus.p1_size = 0; bus.p1_uns = 0; bus.p1_wdata = 0;

        //            we addr   sz    uns wdata                   lat err rdata                   widx wval
        tbl[0]  = '{1, 8'h08, 2'd3, 0, 64'h0123456789ABCDEF, 2, 0, 64'h0,                  1, 64'h0123456789ABCDEF};
        tbl[1]  = '{0, 8'h08, 2'd3, 0, 64'h0,                2, 0, 64'h0123456789ABCDEF,  -1, 64'h0};
        tbl[2]  = '{1, 8'h18, 2'd3, 0, 64'h1111111111111111, 2, 0, 64'h0123456789ABCDEF,  3, 64'h1111111111111111};
        tbl[3]  = '{1, 8'h1D, 2'd0, 0, 64'h55555555555555AB, 3, 0, 64'h0123456789ABCDEF,  3, 64'h1111AB1111111111};
        tbl[4]  = '{0, 8'h1D, 2'd0, 0, 64'h0,                2, 0, 64'hFFFFFFFFFFFFFFAB, -1, 64'h0};
        tbl[5]  = '{0, 8'h1D, 2'd0, 1, 64'h0,                2, 0, 64'h00000000000000AB, -1, 64'h0};
        tbl[6]  = '{0, 8'h06, 2'd2, 0, 64'h0,                1, 1, 64'h00000000000000AB, -1, 64'h0};
        tbl[7]  = '{1, 8'h1A, 2'd1, 0, 64'h000000000000BEEF, 3, 0, 64'h00000000000000AB,  3, 64'h1111AB11BEEF1111};
        tbl[8]  = '{0, 8'h1A, 2'd1, 0, 64'h0,                2, 0, 64'hFFFFFFFFFFFFBEEF, -1, 64'h0};
        tbl[9]  = '{0, 8'h1C, 2'd2, 1, 64'h0,                2, 0, 64'h000000001111AB11, -1, 64'h0};
        tbl[10] = '{1, 8'h1C, 2'd2, 0, 64'h0000000080000000, 3, 0, 64'h000000001111AB11,  3, 64'h80000000BEEF1111};
        tbl[11] = '{0, 8'h1C, 2'd2, 0, 64'h0,                2, 0, 64'hFFFFFFFF80000000, -1, 64'h0};
        tbl[12] = '{1, 8'h03, 2'd1, 0, 64'h0000000000001234, 1, 1, 64'hFFFFFFFF80000000,  3, 64'h80000000BEEF1111};
        tbl[13] = '{0, 8'h0C, 2'd3, 0, 64'h0,                1, 1, 64'hFFFFFFFF80000000, -1, 64'h0};
        tbl[14] = '{0, 8'h1F, 2'd0, 0, 64'h0,                2, 0, 64'hFFFFFFFFFFFFFF80, -1, 64'h0};
        tbl[15] = '{0, 8'h1B, 2'd0, 0, 64'h0,                2, 0, 64'hFFFFFFFFFFFFFFBE, -1, 64'h0};

        // Reset state.
        #2;
        check("rst_mem_we",   64'(bus.mem_we), 64'd0);
        check("rst_mem_endr", 64'(bus.mem_endr), 64'd0);
        check("rst_mem_din",  bus.mem_din, 64'd0);
        check("rst_ack",      64'({bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err}), 64'd0);
        check("rst_rdata0",   bus.p0_rdata, 64'd0);
        check("rst_rdata1",   bus.p1_rdata, 64'd0);
        check("rst_state",    64'(dbg_state), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed table on port 0.
        for (int i = 0; i < 16; i++) begin
            do_txn(1'b0, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata, lat, err, rd, wc, oth);
            check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
            check($sformatf("tbl%0d_err", i), 64'(err), 64'(tbl[i].err));
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
            check($sformatf("tbl%0d_mem_we_cycles", i), 64'(wc), (tbl[i].we && !tbl[i].err) ? 64'd1 : 64'd0);
            if (tbl[i].widx >= 0) check($sformatf("tbl%0d_mem_word", i), mem[tbl[i].widx], tbl[i].wval);
        end
        exp_rdata[0] = tbl[15].rdata;
        exp_rdata[1] = '0;

        // Fill every word with random data through the DUT, then random traffic.
        for (int w = 0; w < 32; w++) run_check(1'b0, 1'b1, 8'(8*w), 2'd3, 1'b0, {$urandom, $urandom});
        for (int i = 0; i < 60; i++) begin
            sz = $urandom_range(0, 3);
            a  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~8'((1 << sz) - 1);
`ifdef MEMCTRL_DEBUG_PORT_EN
            run_check(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 2'(sz), 1'($urandom_range(0, 1)), {$urandom, $urandom});
`else
            run_check(1'b0, 1'($urandom_range(0, 1)), a, 2'(sz), 1'($urandom_range(0, 1)), {$urandom, $urandom});
`endif
        end

        // Reset during the WRITE cycle of a half store to word 4.
        @(posedge clk); #1;
        bus.p0_we = 1'b1; bus.p0_addr = 8'h22; bus.p0_size = 2'd1; bus.p0_uns = 1'b0;
        bus.p0_wdata = 64'h000000000000A5A5; bus.p0_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rmw_mem_we_in_write", 64'(bus.mem_we), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        bus.p0_req = 1'b0;
        check("rmw_rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rmw_rst_mem_endr", 64'(bus.mem_endr), 64'd0);
        check("rmw_rst_mem_din", bus.mem_din, 64'd0);
        check("rmw_rst_rdata0", bus.p0_rdata, 64'd0);
        check("rmw_rst_rdata1", bus.p1_rdata, 64'd0);
        check("rmw_rst_state", 64'(dbg_state), 64'd0);
        @(posedge clk); #1;
        check("rmw_rst_ack", 64'({bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err}), 64'd0);
        check("rmw_rst_word4", mem[4], ref_word(4));
        rst_n = 1'b1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;

`ifdef MEMCTRL_DEBUG_PORT_EN
        // Both ports request from reset and keep requesting: p0, p1, p0, p1.
        begin
            int order[$];
            int first_lat;
            logic [63:0] p1_seen;
            first_lat = -1;
            p1_seen = '0;
            @(posedge clk); #1;
            bus.p0_we = 0; bus.p0_addr = 8'h08; bus.p0_size = 2'd3; bus.p0_uns = 0; bus.p0_req = 1'b1;
            bus.p1_we = 0; bus.p1_addr = 8'h0A; bus.p1_size = 2'd1; bus.p1_uns = 1; bus.p1_req = 1'b1;
            for (int k = 1; k <= 40; k++) begin
                @(posedge clk); #1;
                if (bus.p0_ack) begin
                    order.push_back(0);
                    if (first_lat < 0) first_lat = k;
                end
                if (bus.p1_ack) begin
                    order.push_back(1);
                    p1_seen = bus.p1_rdata;
                end
                if (order.size() >= 4) break;
            end
            bus.p0_req = 1'b0;
            bus.p1_req = 1'b0;
            check("arb_first_latency", 64'(first_lat), 64'd2);
            for (int i = 0; i < 4; i++)
                check($sformatf("arb_order%0d", i), (i < order.size()) ? 64'(order[i]) : 64'd9, 64'(i % 2));
            check("arb_p1_rdata", p1_seen, ref_load(8'h0A, 1, 1'b1));
        end
`else
        // Port 1 requests continuously but is ignored; port 0 unaffected.
        @(posedge clk); #1;
        bus.p1_we = 0; bus.p1_addr = 8'h10; bus.p1_size = 2'd3; bus.p1_uns = 0; bus.p1_req = 1'b1;
        do_txn(1'b0, 1'b0, 8'h08, 2'd3, 1'b0, 64'h0, lat, err, rd, wc, oth);
        check("cfg_p0_latency", 64'(lat), 64'd2);
        check("cfg_p0_rdata", rd, ref_load(8'h08, 3, 1'b0));
        check("cfg_p1_ack_seen", 64'(oth), 64'd0);
        check("cfg_p1_rdata", bus.p1_rdata, 64'd0);
        check("cfg_p1_err", 64'(bus.p1_err), 64'd0);
        bus.p1_req = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store sequencer and two-port arbiter in front of the 64-bit × 32-entry data memory (5-bit word index, combinational read, write on rising `clk` when `We` is high). It shares the memory between the core load/store port (port 0) and the debug/loader port (port 1). It performs byte, half, word and doubleword accesses, using read-modify-write for sub-doubleword stores, and zero- or sign-extends load data. It is the only master of the memory's `endr`, `We` and `din` inputs.

## Interface
Parameters:
- `ADDR_W`, default 8: byte-address width. Word index is `addr[ADDR_W-1:3]`, byte offset is `addr[2:0]`. It must equal 8 for the 32-entry memory.

Ports (`pN_*` is one set each for N = 0, 1):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pN_req`  in  1  request valid; held with all fields stable until ack.
- `pN_we`  in  1  1 = store, 0 = load.
- `pN_addr`  in  ADDR_W  byte address.
- `pN_size`  in  2  00 byte, 01 half, 10 word, 11 doubleword.
- `pN_uns`  in  1  load zero-extends when 1, sign-extends when 0.
- `pN_wdata`  in  64  store data, right-aligned (bits [8·2^size−1:0] used).
- `pN_rdata`  out  64  last load result for this port (registered).
- `pN_ack`  out  1  one-cycle completion pulse.
- `pN_err`  out  1  misalignment flag, valid with ack.
- `mem_endr`  out  ADDR_W-3  memory word index.
- `mem_we`  out  1  memory write enable.
- `mem_din`  out  64  memory write data.
- `mem_dout`  in  64  memory read data (combinational from `mem_endr`).

## Operation
- Request fields are captured into internal registers at grant. `mem_endr`, `mem_we` and `mem_din` decode only from state and captured registers, with no combinational path from `pN_*` inputs.
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE: arbitrate among asserted `pN_req`. With no request, stay in IDLE.
  - Misaligned requests go directly to RESP with err=1. A request is misaligned when: half with `addr[0]`≠0; word with `addr[1:0]`≠0; doubleword with `addr[2:0]`≠0.
  - Aligned requests go to ACCESS.
- ACCESS: `mem_endr` = captured word index.
  - Load: extract the lane at byte offset, extend per `uns`/size, register into the granted port's rdata, then go to RESP.
  - Doubleword store: `mem_we`=1, `mem_din`=wdata, then go to RESP.
  - Sub-doubleword store: capture `mem_dout` with the new lane merged at the byte offset into a merge register, then go to WRITE.
- WRITE: `mem_we`=1, `mem_din`=merge register, `mem_endr` held, then go to RESP.
- RESP: assert the granted port's `ack` (and `err` if set) for one cycle, then go to IDLE.
- Arbitration is round-robin. When both ports request, grant goes to the port not granted last. The last-granted register resets to port 1, so port 0 wins the first tie. A lone requester is always granted.
- The requester must deassert `req`, or present a new request, in the cycle after `ack`. A `req` seen in IDLE is always a new transaction.
- `pN_rdata` changes only on completion of that port's aligned load. Stores and errored requests leave it unchanged.
- Bytes outside the addressed lane are preserved on every store.

## Timing
- Reset (async, immediate): state=IDLE. All outputs are 0: `mem_we`, `mem_endr`, `mem_din`, both ack, err and rdata. Last-granted = port 1.
- Reset mid-transaction aborts it with no ack. `mem_we` drops immediately on reset assertion. A WRITE cut by reset must not commit.
- Latency, with the cycle in which req is first seen in IDLE counted as cycle 0:
  - Misaligned: ack in cycle 1.
  - Load and doubleword store: ack in cycle 2.
  - Sub-doubleword store: ack in cycle 3.
- Memory writes commit at the rising edge ending ACCESS (doubleword store) or WRITE (sub-doubleword store). Loaded data is visible on `pN_rdata` in the ack cycle.
- Minimum spacing between back-to-back transactions is one IDLE cycle.

## Configuration
- `MEMCTRL_DEBUG_PORT_EN` defined: port 1 is fully functional as described.
- `MEMCTRL_DEBUG_PORT_EN` undefined:
  - Port 1 pins remain present, but `p1_req` is ignored.
  - `p1_ack`, `p1_err` and `p1_rdata` are constant 0.
  - The arbiter logic is removed and port 0 is always granted.
  - Port 0 latencies are unchanged.

## Test plan
- Doubleword store then load: p0 stores 0x0123456789ABCDEF at addr 0x08, then loads it back. Ack for each in cycle 2, rdata = 0x0123456789ABCDEF, word 1 written.
- Byte store RMW: word 3 preloaded with 0x1111111111111111; p0 stores byte 0xAB at addr 0x1D. Ack in cycle 3, word 3 = 0x1111AB1111111111. A signed byte load from 0x1D returns 0xFFFFFFFFFFFFFFAB; with uns=1 it returns 0x00000000000000AB.
- Misalignment: p0 loads a word at addr 0x06. Ack+err in cycle 1, `mem_we` never asserted, p0_rdata unchanged.
- Arbitration: p0 and p1 both request from reset. Order of service is p0, p1. With both held continuously with new requests, service alternates p0, p1, p0.
- Reset mid-RMW: assert rst_n=0 during WRITE of a half store. `mem_we` drops immediately, target word unchanged, no ack, all outputs 0.
- Config: with `MEMCTRL_DEBUG_PORT_EN` undefined, p1_req=1 continuously produces no p1_ack, and p0 still completes in cycle 2.
